// File: rtl/conv_weight_ctrl.sv
// Convolution weight-path sequencer: drives the conv state bus and walks the
// weight ROM through every kernel set (KK weights, then one bias word each).
module conv_weight_ctrl #(
    parameter int KERNEL_SIZE      = 3,
    parameter int TOTAL_WEIGHT     = 4,
    parameter int WEIGHT_ROM_DEPTH = 64,
    parameter int PRELOAD_CYCLES   = 6,
    localparam int KK     = KERNEL_SIZE * KERNEL_SIZE,
    localparam int ADDR_W = (WEIGHT_ROM_DEPTH > 1) ? $clog2(WEIGHT_ROM_DEPTH) : 1,
    localparam int KIDX_W = (TOTAL_WEIGHT > 1) ? $clog2(TOTAL_WEIGHT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_load_done,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [KIDX_W-1:0] o_kernel_idx,
    output logic              o_weight_valid,
    output logic              o_bias_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam int SHIFT_W = $clog2(KK) + 1;
    localparam int PRE_W   = $clog2(PRELOAD_CYCLES) + 1;

    localparam logic [ADDR_W-1:0]  SET_STRIDE = ADDR_W'(KK + 1);
    localparam logic [ADDR_W-1:0]  BIAS_OFS   = ADDR_W'(KK);
    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(KK - 1);
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(PRELOAD_CYCLES - 1);
    localparam logic [KIDX_W-1:0]  KIDX_LAST  = KIDX_W'(TOTAL_WEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_LOAD    = 3'd2,
        S_SHIFT   = 3'd3,
        S_BIAS    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [KIDX_W-1:0]   r_kernel_idx;
    logic [PRE_W-1:0]    r_pre_cnt;
    logic [SHIFT_W-1:0]  r_shift_cnt;
    logic                r_weight_valid;
    logic                r_bias_valid;
    logic                r_busy;
    logic                r_done;

    state_t              w_next_state;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [KIDX_W-1:0]   w_next_kidx;
    logic [PRE_W-1:0]    w_next_pre;
    logic [SHIFT_W-1:0]  w_next_shift;
    logic [ADDR_W-1:0]   w_base;

    // Base address of the current kernel set; sets are packed KK+1 words apart.
    assign w_base = ADDR_W'(r_kernel_idx) * SET_STRIDE;

    // Next-state, next-address and counter logic; abort overrides everything.
    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_rom_addr;
        w_next_kidx  = r_kernel_idx;
        w_next_pre   = r_pre_cnt;
        w_next_shift = r_shift_cnt;
        if (i_abort) begin
            w_next_state = S_IDLE;
            w_next_addr  = '0;
            w_next_kidx  = '0;
            w_next_pre   = '0;
            w_next_shift = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_next_state = S_PRELOAD;
                        w_next_addr  = '0;
                        w_next_kidx  = '0;
                        w_next_pre   = '0;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_PRELOAD: begin
                    w_next_addr = '0;
                    if (r_pre_cnt == PRE_LAST) begin
                        w_next_state = S_LOAD;
                        w_next_addr  = w_base;
                        w_next_pre   = '0;
                    end else begin
                        w_next_pre = r_pre_cnt + PRE_W'(1);
                    end
                end
                S_LOAD: begin
                    w_next_addr = w_base;
                    if (i_load_done) begin
                        w_next_state = S_SHIFT;
                        w_next_shift = '0;
                    end else begin
                        w_next_state = S_LOAD;
                    end
                end
                S_SHIFT: begin
                    // The address for the next cycle is base + (j+1); after the last weight that is the bias word.
                    w_next_addr = w_base + ADDR_W'(r_shift_cnt) + ADDR_W'(1);
                    if (r_shift_cnt == SHIFT_LAST) begin
                        w_next_state = S_BIAS;
                        w_next_addr  = w_base + BIAS_OFS;
                        w_next_shift = '0;
                    end else begin
                        w_next_shift = r_shift_cnt + SHIFT_W'(1);
                    end
                end
                S_BIAS: begin
                    if (r_kernel_idx < KIDX_LAST) begin
                        w_next_state = S_LOAD;
                        w_next_kidx  = r_kernel_idx + KIDX_W'(1);
                        w_next_addr  = w_base + SET_STRIDE;
                    end else begin
                        w_next_state = S_DONE;
                        w_next_addr  = '0;
                    end
                end
                S_DONE: begin
                    w_next_state = S_IDLE;
                    w_next_addr  = '0;
                    w_next_kidx  = '0;
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_addr  = '0;
                    w_next_kidx  = '0;
                    w_next_pre   = '0;
                    w_next_shift = '0;
                end
            endcase
        end
    end

    // State, counters and all output flags; valid flags trail the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_rom_addr     <= '0;
            r_kernel_idx   <= '0;
            r_pre_cnt      <= '0;
            r_shift_cnt    <= '0;
            r_weight_valid <= 1'b0;
            r_bias_valid   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_rom_addr     <= w_next_addr;
            r_kernel_idx   <= w_next_kidx;
            r_pre_cnt      <= w_next_pre;
            r_shift_cnt    <= w_next_shift;
            r_weight_valid <= (r_state == S_SHIFT);
            r_bias_valid   <= (r_state == S_BIAS);
            r_busy         <= (w_next_state != S_IDLE);
            r_done         <= (w_next_state == S_DONE);
        end
    end

    assign o_state        = r_state;
    assign o_rom_addr     = r_rom_addr;
    assign o_kernel_idx   = r_kernel_idx;
    assign o_weight_valid = r_weight_valid;
    assign o_bias_valid   = r_bias_valid;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_conv_weight_ctrl.sv
// Self-checking bench for conv_weight_ctrl: a table-driven full run followed by
// hand-written sequences for load stalls, abort, mid-run reset and start/abort collisions.
module tb_conv_weight_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic       i_abort;
    logic       i_load_done;
    logic [2:0] o_state;
    logic [5:0] o_rom_addr;
    logic [1:0] o_kernel_idx;
    logic       o_weight_valid;
    logic       o_bias_valid;
    logic       o_busy;
    logic       o_done;

    conv_weight_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_load_done    (i_load_done),
        .o_state        (o_state),
        .o_rom_addr     (o_rom_addr),
        .o_kernel_idx   (o_kernel_idx),
        .o_weight_valid (o_weight_valid),
        .o_bias_valid   (o_bias_valid),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic start;
        logic abort;
        logic ld;
        int   st;
        int   addr;   // -1: address not checked
        int   kidx;
        int   wv;
        int   bv;
        int   busy;
        int   done;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   wv_cnt   = 0;
    int   bv_cnt   = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, clock once, then sample 1ns after the next edge.
    task automatic step(input logic s, input logic a, input logic ld);
        i_start     = s;
        i_abort     = a;
        i_load_done = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int st, input int addr, input int kidx,
                           input int wv, input int bv, input int busy, input int done);
        check({tag, ".state"}, 32'(o_state), 32'(st));
        if (addr >= 0) check({tag, ".addr"}, 32'(o_rom_addr), 32'(addr));
        check({tag, ".kidx"}, 32'(o_kernel_idx), 32'(kidx));
        check({tag, ".flags"}, {28'd0, o_weight_valid, o_bias_valid, o_busy, o_done},
              {28'd0, wv[0], bv[0], busy[0], done[0]});
    endtask

    initial begin
        int prev_st;
        vec_t v;

        // Expected timeline of one uninterrupted run with load_done held high.
        prev_st = 0;
        for (int c = 1; c <= 53; c++) begin
            v.start = (c == 1);
            v.abort = 1'b0;
            v.ld    = 1'b1;
            if (c <= 6) begin
                v.st = 1; v.addr = 0; v.kidx = 0;
            end else if (c <= 50) begin
                int off, k, p;
                off = c - 7; k = off / 11; p = off % 11;
                v.kidx = k;
                if (p == 0) begin
                    v.st = 2; v.addr = k * 10;
                end else if (p <= 9) begin
                    v.st = 3; v.addr = k * 10 + p - 1;
                end else begin
                    v.st = 4; v.addr = k * 10 + 9;
                end
            end else if (c == 51) begin
                v.st = 5; v.addr = -1; v.kidx = 3;
            end else begin
                v.st = 0; v.addr = 0; v.kidx = 0;
            end
            v.wv   = (prev_st == 3) ? 1 : 0;
            v.bv   = (prev_st == 4) ? 1 : 0;
            v.busy = (v.st != 0) ? 1 : 0;
            v.done = (v.st == 5) ? 1 : 0;
            prev_st = v.st;
            vecs.push_back(v);
        end

        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].abort, vecs[i].ld);
            chk_all($sformatf("run.c%0d", i + 1), vecs[i].st, vecs[i].addr, vecs[i].kidx,
                    vecs[i].wv, vecs[i].bv, vecs[i].busy, vecs[i].done);
            wv_cnt   += int'(o_weight_valid);
            bv_cnt   += int'(o_bias_valid);
            done_cnt += int'(o_done);
        end
        check("run.weight_valid_count", 32'(wv_cnt), 32'd36);
        check("run.bias_valid_count", 32'(bv_cnt), 32'd4);
        check("run.done_count", 32'(done_cnt), 32'd1);

        // Load stall: load_done low for 5 LOAD cycles, start pulses during SHIFT, abort from BIAS.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
        chk_all("stall.load0", 2, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk_all($sformatf("stall.hold%0d", i), 2, 0, 0, 0, 0, 1, 0);
        end
        step(1'b0, 1'b0, 1'b1);
        chk_all("stall.shift0", 3, 0, 0, 0, 0, 1, 0);
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, 1'b0, 1'b1);
            chk_all($sformatf("stall.shift%0d", j), 3, j, 0, 1, 0, 1, 0);
        end
        step(1'b1, 1'b0, 1'b1);
        chk_all("stall.bias", 4, 9, 0, 1, 0, 1, 0);
        step(1'b0, 1'b1, 1'b1);
        chk_all("stall.abort_bias", 0, 0, 0, 0, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("stall.idle", 0, 0, 0, 0, 0, 0, 0);

        // Abort at SHIFT j=4 of set 2, then restart from kernel 0.
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 33; i++) step(1'b0, 1'b0, 1'b1);
        chk_all("abort.shift4", 3, 24, 2, 1, 0, 1, 0);
        step(1'b0, 1'b1, 1'b1);
        chk_all("abort.idle", 0, 0, 0, 1, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1);
        chk_all("abort.idle2", 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b1);
        chk_all("abort.restart", 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
        chk_all("abort.load", 2, 0, 0, 0, 0, 1, 0);
        step(1'b0, 1'b1, 1'b1);
        chk_all("abort.over_load_done", 0, 0, 0, 0, 0, 0, 0);

        // Reset asserted during BIAS of set 1.
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 27; i++) step(1'b0, 1'b0, 1'b1);
        chk_all("rst.bias1", 4, 19, 1, 1, 0, 1, 0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        chk_all("rst.cleared", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        chk_all("rst.idle", 0, 0, 0, 0, 0, 0, 0);

        // Start and abort together in IDLE.
        step(1'b1, 1'b1, 1'b0);
        chk_all("collide.idle", 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("collide.idle2", 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_weight_ctrl.md
Name: conv_weight_ctrl

Overview:
- Sequencer for the convolution weight path. It drives the shared 3-bit conv state bus and the weight ROM address.
- Steps through TOTAL_WEIGHT kernel sets. Each set is KERNEL_SIZE*KERNEL_SIZE weights followed by one bias word, stored contiguously in the weight ROM.
- Sits between the layer top (start/done handshake) and the input line buffer (load-done), and feeds the weight buffer and PE array.

Parameters:
- KERNEL_SIZE, 3: kernel edge. KK = KERNEL_SIZE*KERNEL_SIZE weights per set.
- TOTAL_WEIGHT, 4: number of kernel sets.
- WEIGHT_ROM_DEPTH, 64: ROM words. Must satisfy TOTAL_WEIGHT*(KK+1) <= WEIGHT_ROM_DEPTH.
- PRELOAD_CYCLES, 6: cycles spent in PRELOAD (line-buffer prefill).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_start  in  1  start pulse; sampled in IDLE only.
- i_abort  in  1  synchronous abort; any state returns to IDLE.
- i_load_done  in  1  input buffer ready for the next kernel pass.
- o_state  out  3  conv state bus: IDLE=0, PRELOAD=1, LOAD=2, SHIFT=3, BIAS=4, DONE=5.
- o_rom_addr  out  logb2(WEIGHT_ROM_DEPTH)  weight ROM address (asynchronous-read ROM).
- o_kernel_idx  out  logb2(TOTAL_WEIGHT)  current kernel set.
- o_weight_valid  out  1  registered weight word valid this cycle.
- o_bias_valid  out  1  registered bias word valid this cycle.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse, high while o_state==DONE.

Behaviour:
- All outputs are registered.
- Reset values: o_state=IDLE, o_rom_addr=0, o_kernel_idx=0, all flags=0, internal counters=0.
- Reset asserted mid-operation returns everything to these values on the next edge. No done pulse is generated.
- Base address for set k: base(k) = k*(KK+1).
- IDLE:
  - i_start=1 -> PRELOAD, counter cleared, o_kernel_idx=0.
  - Otherwise remain in IDLE.
- PRELOAD:
  - Held for exactly PRELOAD_CYCLES cycles, then -> LOAD.
  - o_rom_addr=0.
- LOAD:
  - o_rom_addr=base(o_kernel_idx).
  - Wait for i_load_done=1, then -> SHIFT. LOAD lasts at least 1 cycle.
  - An i_load_done seen in other states is ignored (not latched).
- SHIFT:
  - Exactly KK cycles.
  - In the j-th SHIFT cycle (j=0..KK-1), o_rom_addr=base+j.
  - After the last cycle -> BIAS.
- BIAS:
  - One cycle, o_rom_addr=base+KK.
  - If o_kernel_idx < TOTAL_WEIGHT-1: o_kernel_idx increments, -> LOAD.
  - Else -> DONE.
- DONE: one cycle, o_done=1, -> IDLE. o_kernel_idx clears on entry to IDLE.
- Valid flags lag state by one cycle, aligned with the weight buffer's registered output:
  - o_weight_valid(t) = (o_state(t-1)==SHIFT).
  - o_bias_valid(t) = (o_state(t-1)==BIAS).
  - The flags therefore also fire for one cycle after i_abort leaves SHIFT/BIAS.
- Simultaneous events:
  - i_abort has priority over all transitions, including i_start in IDLE and i_load_done in LOAD.
  - i_start while busy is ignored.
- Counters wrap-safe: the SHIFT counter is sized logb2(KK)+1 bits and clears on every entry to SHIFT.
- Address arithmetic is unsigned; the highest address is TOTAL_WEIGHT*(KK+1)-1 (39 at defaults). No wrap past the ROM is permitted.

Test Plan (defaults: KK=9, 4 sets; start sampled at edge 0):
- Single run, i_load_done held high:
  - PRELOAD cycles 1-6, LOAD 7, SHIFT 8-16 with addr 0..8, BIAS 17 with addr 9.
  - o_weight_valid high cycles 9-17; o_bias_valid high cycle 18.
- Full run, i_load_done held high:
  - Sets 1, 2, 3 use addrs 10-19, 20-29, 30-39.
  - Exactly 36 weight-valid and 4 bias-valid cycles; o_done pulses once.
  - Total 6 PRELOAD + 4*(1+9+1) + 1 DONE cycles, then IDLE.
- i_load_done low for 5 cycles in LOAD -> state holds LOAD and addr holds base(k) for exactly those cycles; then SHIFT proceeds normally.
- i_abort at SHIFT cycle j=4 of set 2 -> IDLE next cycle, o_busy=0, no o_done. A later i_start restarts from kernel 0, addr 0.
- rst asserted during BIAS of set 1 -> all outputs at reset values next cycle.
- i_start pulses during SHIFT have no effect; i_start and i_abort together in IDLE -> remain IDLE.
